encoder_8_3_serial: RTL and testbench
=====================================

// Module: encoder_8_3_serial
// PURPOSE
//  Sequential priority encoder: the inverse of the team's 2-4/3-8 one-hot decoders.
//  Accepts an N-bit request vector (one-hot or multi-hot) over a valid/ready handshake.
//  Emits the binary index of every set bit, one per handshake, highest index first.
//  Sits between request/interrupt vectors and index-consuming logic (mux selects, decoder inputs).
// PARAMETERS
//  N  8  request vector width (>=2)
//  W  3  code width; must equal $clog2(N)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  E          in   1   enable; low = freeze all state (stall)
//  In_valid   in   1   request vector valid
//  In_ready   out  1   block can accept a vector
//  In         in   N   request vector
//  Out_valid  out  1   Out holds a valid index
//  Out_ready  in   1   consumer accepts Out
//  Out        out  W   binary index of highest pending bit
//  Out_last   out  1   Out is the final index of the current vector
//  Zero       out  1   one-cycle pulse: an all-zero vector was accepted
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, overrides everything, incl. mid-scan):
//   - state=IDLE; pending register pend=0
//   - In_ready=0 while rst=1; Out_valid=0, Out=0, Out_last=0, Zero=0
//  State IDLE:
//   - In_ready = E; Out_valid = 0
//   - Accept when In_valid & In_ready.
//   - If In!=0: pend<=In, go SCAN.
//   - If In==0: stay IDLE, Zero=1 for the next cycle only, no Out produced.
//  State SCAN:
//   - In_ready = 0
//   - Out_valid = E
//   - Out = index of highest set bit in pend
//   - Out_last = (pend has exactly one bit set)
//   - Out, Out_last derived only from registered pend; no comb path from In/In_valid.
//   - On Out_valid & Out_ready: clear that bit in pend.
//     If Out_last, go IDLE (In_ready high the following cycle).
//   - Out_valid=1 & Out_ready=0: hold Out/Out_last/pend stable until taken.
//  Enable:
//   - E=0 freezes state and pend.
//   - Gates In_ready and Out_valid low; no handshake completes.
//   - Zero still clears.
//  Latency / throughput:
//   - Vector accepted at edge T gives first Out_valid in cycle T+1.
//   - With Out_ready held high, k set bits take k consecutive cycles.
//   - Then 1 IDLE cycle before the next accept.
//  Widths: indices 0..N-1 in W bits, unsigned; bits >=N never produced.
//  Out holds its last value in IDLE (don't-care when Out_valid=0; bench ignores).
// TESTING
//  1. In=8'b1010_0100, Out_ready=1 -> Out=7,5,2 on 3 consecutive cycles;
//     Out_last=1 only with 2; In_ready=1 again 1 cycle later.
//  2. In=8'h81, Out_ready low 3 cycles after first Out_valid -> Out=7 held
//     stable 3 cycles, then 7,0 with last on 0.
//  3. In=8'h00 accepted -> Zero=1 one cycle; Out_valid stays 0; In_ready stays 1.
//  4. In=8'hFF, E dropped for 2 cycles after Out=5 taken -> Out_valid=0 both cycles;
//     resumes Out=4..0, 8 indices total.
//  5. rst=1 mid-scan of In=8'h3C after Out=5 -> next cycle IDLE, Out_valid=0;
//     new In=8'h01 gives Out=0, Out_last=1.
//  6. Back-to-back singles 8'h01,8'h40,8'h08 with In_valid held high ->
//     Out=0,6,3 each with Out_last=1, accepts every 2 cycles.

Source files
------------

// File: rtl/encoder_8_3_serial.sv
// Sequential priority encoder: accepts a request vector and emits the index of
// every set bit, highest first, one per output handshake.
module encoder_8_3_serial #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         E,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [N-1:0] In,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [W-1:0] Out,
    output logic         Out_last,
    output logic         Zero
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t       state;
    logic [N-1:0] pend;
    logic [W-1:0] top_idx;
    logic [N-1:0] top_bit;
    logic         single;

    // Highest pending index; looks only at the registered pend vector.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) top_idx = W'(i);
        end
        top_bit = N'(1) << top_idx;
        single  = (pend == top_bit);
    end

    assign In_ready  = !rst && E && (state == IDLE);
    assign Out_valid = !rst && E && (state == SCAN);
    assign Out       = top_idx;
    assign Out_last  = single;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            Zero  <= 1'b0;
        end else begin
            Zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_ready && In_valid) begin
                        if (In != '0) begin
                            pend  <= In;
                            state <= SCAN;
                        end else begin
                            Zero <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Retire the index just taken; the final one returns to IDLE.
                    if (Out_valid && Out_ready) begin
                        pend <= pend & ~top_bit;
                        if (single) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8_3_serial.sv
// Self-checking bench for encoder_8_3_serial: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_encoder_8_3_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       E = 1'b0;
    logic       In_valid = 1'b0;
    logic       In_ready;
    logic [7:0] In = 8'h00;
    logic       Out_valid;
    logic       Out_ready = 1'b0;
    logic [2:0] Out;
    logic       Out_last;
    logic       Zero;

    int vectors = 0;
    int miscompares = 0;

    encoder_8_3_serial #(.N(8), .W(3)) dut (
        .clk(clk), .rst(rst), .E(E),
        .In_valid(In_valid), .In_ready(In_ready), .In(In),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out(Out), .Out_last(Out_last), .Zero(Zero)
    );

    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then let outputs settle before checks.
    task automatic drive(input logic e, input logic iv, input logic [7:0] v, input logic ordy);
        @(negedge clk);
        E = e; In_valid = iv; In = v; Out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h55, 1'b1);
        vectors++; if (In_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %0b want 0", In_ready); end
        vectors++; if (Out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", Out_valid); end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %0b want 0", Zero); end
        vectors++; if (Out !== 3'd0 || Out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out got %0d/%0b want 0/0", Out, Out_last); end
        rst = 1'b0;
        #1;
        vectors++; if (In_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %0b want 1", In_ready); end
    endtask

    task automatic test_multi_bit();
        logic [2:0] exp_idx [3];
        exp_idx[0] = 3'd7; exp_idx[1] = 3'd5; exp_idx[2] = 3'd2;
        drive(1'b1, 1'b1, 8'b1010_0100, 1'b1);
        vectors++; if (In_ready !== 1'b1) begin miscompares++; $display("FAIL t1_accept got %0b want 1", In_ready); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1);
            vectors++; if (Out_valid !== 1'b1 || Out !== exp_idx[k] || Out_last !== (k == 2))
                begin miscompares++; $display("FAIL t1_out%0d got v=%0b idx=%0d last=%0b want v=1 idx=%0d last=%0b", k, Out_valid, Out, Out_last, exp_idx[k], (k == 2)); end
            vectors++; if (In_ready !== 1'b0) begin miscompares++; $display("FAIL t1_busy_ready got %0b want 0", In_ready); end
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin miscompares++; $display("FAIL t1_idle got ir=%0b ov=%0b want 1/0", In_ready, Out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 8'h81, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            vectors++; if (Out_valid !== 1'b1 || Out !== 3'd7 || Out_last !== 1'b0)
                begin miscompares++; $display("FAIL t2_hold%0d got v=%0b idx=%0d last=%0b want 1/7/0", k, Out_valid, Out, Out_last); end
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Out_valid !== 1'b1 || Out !== 3'd7 || Out_last !== 1'b0)
            begin miscompares++; $display("FAIL t2_take7 got v=%0b idx=%0d last=%0b want 1/7/0", Out_valid, Out, Out_last); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Out_valid !== 1'b1 || Out !== 3'd0 || Out_last !== 1'b1)
            begin miscompares++; $display("FAIL t2_take0 got v=%0b idx=%0d last=%0b want 1/0/1", Out_valid, Out, Out_last); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (In_ready !== 1'b1) begin miscompares++; $display("FAIL t2_idle got %0b want 1", In_ready); end
    endtask

    task automatic test_zero();
        drive(1'b1, 1'b1, 8'h00, 1'b1);
        vectors++; if (In_ready !== 1'b1) begin miscompares++; $display("FAIL t3_accept got %0b want 1", In_ready); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Zero !== 1'b1 || Out_valid !== 1'b0 || In_ready !== 1'b1)
            begin miscompares++; $display("FAIL t3_pulse got z=%0b ov=%0b ir=%0b want 1/0/1", Zero, Out_valid, In_ready); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Zero !== 1'b0 || Out_valid !== 1'b0) begin miscompares++; $display("FAIL t3_clear got z=%0b ov=%0b want 0/0", Zero, Out_valid); end
    endtask

    task automatic test_enable_stall();
        int taken = 0;
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            if (k == 4) begin
                for (int s = 0; s < 2; s++) begin
                    drive(1'b0, 1'b1, 8'h00, 1'b1);
                    vectors++; if (Out_valid !== 1'b0 || In_ready !== 1'b0)
                        begin miscompares++; $display("FAIL t4_stall%0d got ov=%0b ir=%0b want 0/0", s, Out_valid, In_ready); end
                end
            end
            drive(1'b1, 1'b0, 8'h00, 1'b1);
            vectors++; if (Out_valid !== 1'b1 || Out !== 3'(k) || Out_last !== (k == 0))
                begin miscompares++; $display("FAIL t4_out got v=%0b idx=%0d last=%0b want 1/%0d/%0b", Out_valid, Out, Out_last, k, (k == 0)); end
            if (Out_valid === 1'b1) taken++;
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (taken != 8 || Out_valid !== 1'b0) begin miscompares++; $display("FAIL t4_count got %0d ov=%0b want 8/0", taken, Out_valid); end
    endtask

    task automatic test_reset_mid_scan();
        drive(1'b1, 1'b1, 8'h3C, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Out !== 3'd5 || Out_valid !== 1'b1) begin miscompares++; $display("FAIL t5_first got %0d v=%0b want 5/1", Out, Out_valid); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Out_valid !== 1'b0 || In_ready !== 1'b0) begin miscompares++; $display("FAIL t5_in_rst got ov=%0b ir=%0b want 0/0", Out_valid, In_ready); end
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h01, 1'b1);
        vectors++; if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin miscompares++; $display("FAIL t5_idle got ov=%0b ir=%0b want 0/1", Out_valid, In_ready); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Out_valid !== 1'b1 || Out !== 3'd0 || Out_last !== 1'b1)
            begin miscompares++; $display("FAIL t5_new got v=%0b idx=%0d last=%0b want 1/0/1", Out_valid, Out, Out_last); end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vecs [3];
        logic [2:0] idx [3];
        vecs[0] = 8'h01; vecs[1] = 8'h40; vecs[2] = 8'h08;
        idx[0] = 3'd0; idx[1] = 3'd6; idx[2] = 3'd3;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, vecs[k], 1'b1);
            vectors++; if (In_ready !== 1'b1) begin miscompares++; $display("FAIL t6_accept%0d got %0b want 1", k, In_ready); end
            drive(1'b1, 1'b1, (k < 2) ? vecs[k+1] : 8'h00, 1'b1);
            vectors++; if (Out_valid !== 1'b1 || Out !== idx[k] || Out_last !== 1'b1 || In_ready !== 1'b0)
                begin miscompares++; $display("FAIL t6_out%0d got v=%0b idx=%0d last=%0b ir=%0b want 1/%0d/1/0", k, Out_valid, Out, Out_last, In_ready, idx[k]); end
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    // Reference model: a queue of indices still owed for the current vector.
    task automatic test_random();
        int q[$];
        logic exp_zero = 1'b0;
        logic e, iv, ordy, exp_ir, exp_ov;
        logic [7:0] v;
        for (int c = 0; c < 400; c++) begin
            e    = ($urandom_range(0, 4) != 0);
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            v    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            drive(e, iv, v, ordy);
            exp_ir = (q.size() == 0) && e;
            exp_ov = (q.size() != 0) && e;
            vectors++; if (In_ready !== exp_ir || Out_valid !== exp_ov || Zero !== exp_zero)
                begin miscompares++; $display("FAIL rnd_ctl c=%0d got ir=%0b ov=%0b z=%0b want %0b/%0b/%0b", c, In_ready, Out_valid, Zero, exp_ir, exp_ov, exp_zero); end
            if (exp_ov) begin
                vectors++; if (Out !== 3'(q[0]) || Out_last !== (q.size() == 1))
                    begin miscompares++; $display("FAIL rnd_out c=%0d got idx=%0d last=%0b want %0d/%0b", c, Out, Out_last, q[0], (q.size() == 1)); end
            end
            exp_zero = 1'b0;
            if (exp_ir && iv) begin
                if (v == 8'h00) exp_zero = 1'b1;
                for (int i = 7; i >= 0; i--) if (v[i]) q.push_back(i);
            end else if (exp_ov && ordy) begin
                void'(q.pop_front());
            end
        end
    endtask

    initial begin
        test_reset();
        test_multi_bit();
        test_backpressure();
        test_zero();
        test_enable_stall();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
